duck_round_gen: RTL and testbench
=================================

Name: duck_round_gen

Overview:
- Upstream stage of the duck position controller: owns round sequencing for one duck flight per round.
- Draws pseudo-random flight parameters (direction, horizontal/vertical speed, start x) from an LFSR and holds them stable for the round.
- Issues a one-cycle restart pulse so the position controller re-enters its draw state, times the round in frames, and decides hit vs. fly-away.
- Keeps shot/miss/round counters for the score and HUD logic.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.
- ROUND_FRAMES, 300, frames of flight before the duck escapes.
- HIT_FRAMES, 60, frames spent in the HIT state.
- ESC_FRAMES, 90, frames spent in the ESCAPE state.
- ROUNDS, 10, rounds per game.
- H_SPD_MIN, 2, minimum horizontal speed; must be ≤24.
- V_SPD_MIN, 2, minimum vertical speed; must be ≤24.
- X_MIN, 256, minimum start x; must satisfy X_MIN+511 ≤ 1023.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- new_frame  in  1  one-cycle pulse per video frame
- round_start  in  1  one-cycle pulse from the game/menu control
- duck_shot  in  1  one-cycle pulse from hit detection
- duck_restart  out  1  one-cycle pulse, active-high, to the position controller reset
- duck_direction  out  1  1 = right, 0 = left
- duck_h_spd  out  5  horizontal pixels per frame
- duck_v_spd  out  5  vertical pixels per frame
- duck_start_x  out  10  start column
- round_active  out  1  high in FLY
- duck_falling  out  1  high in HIT
- fly_away  out  1  high in ESCAPE
- game_over  out  1  high in DONE
- shot_cnt  out  4  ducks hit this game
- miss_cnt  out  4  ducks escaped this game
- round_num  out  4  current round, 0-based

Behaviour:
- Reset (asynchronous, rst low): state = IDLE; all outputs = 0; LFSR = seed; frame counter = 0.
- LFSR: 16-bit Galois, mask 16'hB400, shift right. Advances every clk cycle that is not in reset.
- FSM states: IDLE, LOAD, ARM, FLY, HIT, ESCAPE, DONE.
- IDLE: on round_start, go to LOAD.
- LOAD (1 cycle): register parameters from the current LFSR value:
  - duck_direction = lfsr[0]
  - duck_h_spd = H_SPD_MIN + lfsr[3:1]
  - duck_v_spd = V_SPD_MIN + lfsr[6:4]
  - duck_start_x = X_MIN + lfsr[15:7]
  - All arithmetic is unsigned and zero-extended.
  - Go to ARM.
- ARM (1 cycle): duck_restart = 1; frame counter cleared; go to FLY.
  - duck_restart rises exactly 2 cycles after the round_start pulse.
  - Parameters are stable from the LOAD edge until the next LOAD.
- FLY:
  - Frame counter increments on new_frame.
  - duck_shot → HIT; shot_cnt increments.
  - Otherwise, new_frame with counter == ROUND_FRAMES-1 → ESCAPE; miss_cnt increments.
  - If duck_shot and the timeout occur in the same cycle, the shot wins.
  - The frame counter clears on every state entry.
- HIT: exits after HIT_FRAMES new_frame pulses. duck_shot is ignored.
- ESCAPE: exits after ESC_FRAMES new_frame pulses. duck_shot is ignored.
- Exit from HIT or ESCAPE:
  - If round_num == ROUNDS-1, go to DONE; round_num is held.
  - Otherwise round_num increments and the FSM goes to LOAD.
- DONE: game_over = 1. On round_start, clear shot_cnt, miss_cnt and round_num, then go to LOAD.
- round_start is ignored in every state except IDLE and DONE.
- Counters saturate at 15.
- Outputs are registered; status flags are decoded from the state register.

Optional Feature:
- DUCK_SPEEDUP_EN defined: in LOAD, add round_num>>1 to both duck_h_spd and duck_v_spd, saturating at 31.
- Undefined: speeds are exactly as specified in Behaviour, independent of round.

Test Plan:
- Reset check: hold rst low → all outputs 0, game_over=0. Release → no duck_restart without round_start.
- round_start pulse at cycle N:
  - duck_restart high only at cycle N+2.
  - h_spd, v_spd, start_x and direction match a software Galois model seeded 16'hACE1 and are stable through FLY.
  - 2 ≤ h_spd ≤ 9 and 256 ≤ start_x ≤ 767.
- ROUND_FRAMES=4: 4 new_frame pulses in FLY → fly_away=1, miss_cnt=1. After ESC_FRAMES frames → LOAD, round_num=1.
- duck_shot coincident with the 4th new_frame → duck_falling=1, shot_cnt=1, miss_cnt=0.
- ROUNDS=3, alternate hit/miss → game_over=1 with shot_cnt+miss_cnt=3. A new round_start clears all counters and pulses duck_restart.
- Assert rst low mid-FLY → immediate IDLE with all outputs 0. With DUCK_SPEEDUP_EN, round 4 speeds are 2 higher than the non-speedup model.

Source files
------------

// File: rtl/duck_round_if.sv
// duck_round_if: handshake and status bundle between the duck round
// sequencer and its neighbours (frame timing, menu control, hit detection,
// position controller, score/HUD).
// master: drives the event pulses and observes the round outputs.
// slave : the round sequencer itself.
interface duck_round_if;
  // event pulses into the sequencer
  logic       new_frame;
  logic       round_start;
  logic       duck_shot;
  // flight parameters and restart pulse for the position controller
  logic       duck_restart;
  logic       duck_direction;
  logic [4:0] duck_h_spd;
  logic [4:0] duck_v_spd;
  logic [9:0] duck_start_x;
  // status flags and score counters
  logic       round_active;
  logic       duck_falling;
  logic       fly_away;
  logic       game_over;
  logic [3:0] shot_cnt;
  logic [3:0] miss_cnt;
  logic [3:0] round_num;

  modport master (
    output new_frame, round_start, duck_shot,
    input  duck_restart, duck_direction, duck_h_spd, duck_v_spd, duck_start_x,
    input  round_active, duck_falling, fly_away, game_over,
    input  shot_cnt, miss_cnt, round_num
  );

  modport slave (
    input  new_frame, round_start, duck_shot,
    output duck_restart, duck_direction, duck_h_spd, duck_v_spd, duck_start_x,
    output round_active, duck_falling, fly_away, game_over,
    output shot_cnt, miss_cnt, round_num
  );
endinterface

// File: rtl/duck_round_gen.sv
// duck_round_gen: round sequencer feeding the duck position controller.
// Draws flight parameters from a 16-bit Galois LFSR, pulses duck_restart,
// times the flight in video frames, resolves hit vs. fly-away and keeps the
// shot/miss/round counters for scoring.
// Optional build macro: DUCK_SPEEDUP_EN - when defined, each parameter draw
// adds round_num>>1 to both speeds (saturating at 31).
module duck_round_gen #(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          ROUND_FRAMES = 300,
  parameter int          HIT_FRAMES   = 60,
  parameter int          ESC_FRAMES   = 90,
  parameter int          ROUNDS       = 10,
  parameter int          H_SPD_MIN    = 2,
  parameter int          V_SPD_MIN    = 2,
  parameter int          X_MIN        = 256
) (
  input logic         clk,
  input logic         rst,
  duck_round_if.slave bus
);

  // an all-zero Galois LFSR would lock up, so a zero seed becomes 1
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // one frame counter is shared by FLY, HIT and ESCAPE; size it for the longest
  localparam int MAX_FRAMES =
    (ROUND_FRAMES > HIT_FRAMES) ?
      ((ROUND_FRAMES > ESC_FRAMES) ? ROUND_FRAMES : ESC_FRAMES) :
      ((HIT_FRAMES > ESC_FRAMES) ? HIT_FRAMES : ESC_FRAMES);
  localparam int CNT_W = (MAX_FRAMES < 2) ? 1 : $clog2(MAX_FRAMES);

  localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(ROUND_FRAMES - 1);
  localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
  localparam logic [CNT_W-1:0] ESC_LAST   = CNT_W'(ESC_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [5:0]       H_BASE     = 6'(H_SPD_MIN);
  localparam logic [5:0]       V_BASE     = 6'(V_SPD_MIN);
  localparam logic [9:0]       X_BASE     = 10'(X_MIN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_FLY,
    ST_HIT,
    ST_ESCAPE,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [15:0]      lfsr_reg, lfsr_next;
  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic [3:0]       shot_cnt_reg, shot_cnt_next;
  logic [3:0]       miss_cnt_reg, miss_cnt_next;
  logic [3:0]       round_num_reg, round_num_next;
  logic             dir_reg, dir_next;
  logic [4:0]       h_spd_reg, h_spd_next;
  logic [4:0]       v_spd_reg, v_spd_next;
  logic [9:0]       start_x_reg, start_x_next;

  logic [16:0]      lfsr_ext;
  logic [5:0]       speed_bonus;
  logic [5:0]       h_sum;
  logic [5:0]       v_sum;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

  function automatic logic [4:0] sat_spd(input logic [5:0] value);
    return (value > 6'd31) ? 5'd31 : value[4:0];
  endfunction

  // Galois shift-right step: each bit takes its upper neighbour, tapped bits
  // additionally fold in the bit being shifted out
  assign lfsr_ext = {1'b0, lfsr_reg};
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr
      assign lfsr_next[gi] = lfsr_ext[gi+1] ^ (LFSR_MASK[gi] & lfsr_reg[0]);
    end
  endgenerate

`ifdef DUCK_SPEEDUP_EN
  // later rounds fly faster: +1 pixel/frame every second round
  assign speed_bonus = 6'(round_num_reg >> 1);
`else
  assign speed_bonus = 6'd0;
`endif

  assign h_sum = H_BASE + 6'(lfsr_reg[3:1]) + speed_bonus;
  assign v_sum = V_BASE + 6'(lfsr_reg[6:4]) + speed_bonus;

  // state, LFSR, counters and held flight parameters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      lfsr_reg      <= SEED_EFF;
      frame_cnt_reg <= '0;
      shot_cnt_reg  <= 4'd0;
      miss_cnt_reg  <= 4'd0;
      round_num_reg <= 4'd0;
      dir_reg       <= 1'b0;
      h_spd_reg     <= 5'd0;
      v_spd_reg     <= 5'd0;
      start_x_reg   <= 10'd0;
    end else begin
      state_reg     <= state_next;
      lfsr_reg      <= lfsr_next;
      frame_cnt_reg <= frame_cnt_next;
      shot_cnt_reg  <= shot_cnt_next;
      miss_cnt_reg  <= miss_cnt_next;
      round_num_reg <= round_num_next;
      dir_reg       <= dir_next;
      h_spd_reg     <= h_spd_next;
      v_spd_reg     <= v_spd_next;
      start_x_reg   <= start_x_next;
    end
  end

  // round sequencing: next state, counters and parameter capture
  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    shot_cnt_next  = shot_cnt_reg;
    miss_cnt_next  = miss_cnt_reg;
    round_num_next = round_num_reg;
    dir_next       = dir_reg;
    h_spd_next     = h_spd_reg;
    v_spd_next     = v_spd_reg;
    start_x_next   = start_x_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.round_start) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dir_next     = lfsr_reg[0];
        h_spd_next   = sat_spd(h_sum);
        v_spd_next   = sat_spd(v_sum);
        start_x_next = X_BASE + 10'(lfsr_reg[15:7]);
        state_next   = ST_ARM;
      end
      ST_ARM: begin
        state_next = ST_FLY;
      end
      ST_FLY: begin
        // a shot landing on the timeout frame still counts as a hit
        if (bus.duck_shot) begin
          state_next    = ST_HIT;
          shot_cnt_next = sat_inc4(shot_cnt_reg);
        end else if (bus.new_frame) begin
          if (frame_cnt_reg == ROUND_LAST) begin
            state_next    = ST_ESCAPE;
            miss_cnt_next = sat_inc4(miss_cnt_reg);
          end else begin
            frame_cnt_next = frame_cnt_reg + CNT_ONE;
          end
        end
      end
      ST_HIT, ST_ESCAPE: begin
        if (bus.new_frame) begin
          if (frame_cnt_reg == ((state_reg == ST_HIT) ? HIT_LAST : ESC_LAST)) begin
            if (round_num_reg == LAST_ROUND) begin
              state_next = ST_DONE;
            end else begin
              round_num_next = sat_inc4(round_num_reg);
              state_next     = ST_LOAD;
            end
          end else begin
            frame_cnt_next = frame_cnt_reg + CNT_ONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.round_start) begin
          shot_cnt_next  = 4'd0;
          miss_cnt_next  = 4'd0;
          round_num_next = 4'd0;
          state_next     = ST_LOAD;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // every state starts timing from zero
    if (state_next != state_reg) begin
      frame_cnt_next = '0;
    end
  end

  assign bus.duck_restart   = (state_reg == ST_ARM);
  assign bus.round_active   = (state_reg == ST_FLY);
  assign bus.duck_falling   = (state_reg == ST_HIT);
  assign bus.fly_away       = (state_reg == ST_ESCAPE);
  assign bus.game_over      = (state_reg == ST_DONE);
  assign bus.duck_direction = dir_reg;
  assign bus.duck_h_spd     = h_spd_reg;
  assign bus.duck_v_spd     = v_spd_reg;
  assign bus.duck_start_x   = start_x_reg;
  assign bus.shot_cnt       = shot_cnt_reg;
  assign bus.miss_cnt       = miss_cnt_reg;
  assign bus.round_num      = round_num_reg;

endmodule

// File: tb/tb_duck_round_gen.sv
// tb_duck_round_gen: self-checking bench for duck_round_gen with short
// round timing (4 flight frames, 3 hit frames, 5 escape frames, 3 rounds).
module tb_duck_round_gen;
  localparam int RF        = 4;
  localparam int HF        = 3;
  localparam int EF        = 5;
  localparam int NR        = 3;
  localparam int H_SPD_MIN = 2;
  localparam int V_SPD_MIN = 2;
  localparam int X_MIN     = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  int exp_shot = 0;
  int exp_miss = 0;
  int exp_round = 0;
  logic [15:0] lfsr_m = 16'hACE1;

  duck_round_if bus_if ();

  duck_round_gen #(
    .ROUND_FRAMES(RF),
    .HIT_FRAMES  (HF),
    .ESC_FRAMES  (EF),
    .ROUNDS      (NR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // reference LFSR: seeded while reset is low, one Galois step per clock otherwise
  function automatic logic [15:0] galois_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m <= 16'hACE1;
    else      lfsr_m <= galois_step(lfsr_m);
  end

  // expected {direction, h_spd, v_spd, start_x} drawn from LFSR value l in round rnd
  function automatic logic [20:0] exp_params(input logic [15:0] l, input int rnd);
    int h;
    int v;
    int x;
    h = H_SPD_MIN + int'(l[3:1]);
    v = V_SPD_MIN + int'(l[6:4]);
    x = X_MIN + int'(l[15:7]);
`ifdef DUCK_SPEEDUP_EN
    h = h + rnd / 2;
    v = v + rnd / 2;
    if (h > 31) h = 31;
    if (v > 31) v = 31;
`else
    if (rnd < 0) h = 0;
`endif
    return {l[0], 5'(h), 5'(v), 10'(x)};
  endfunction

  function automatic logic [20:0] params();
    return {bus_if.duck_direction, bus_if.duck_h_spd, bus_if.duck_v_spd, bus_if.duck_start_x};
  endfunction

  function automatic logic [37:0] all_outs();
    return {bus_if.duck_restart, params(), bus_if.round_active, bus_if.duck_falling,
            bus_if.fly_away, bus_if.game_over, bus_if.shot_cnt, bus_if.miss_cnt, bus_if.round_num};
  endfunction

  function automatic logic [12:0] score();
    return {bus_if.game_over, bus_if.shot_cnt, bus_if.miss_cnt, bus_if.round_num};
  endfunction

  // n new_frame pulses with random idle gaps; duck_shot rides on pulse shot_at
  task automatic send_frames(input int n, input int shot_at);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus_if.new_frame = 1'b0;
        bus_if.duck_shot = 1'b0;
        @(negedge clk);
      end
      bus_if.new_frame = 1'b1;
      bus_if.duck_shot = (i == shot_at);
      @(negedge clk);
      bus_if.new_frame = 1'b0;
      bus_if.duck_shot = 1'b0;
    end
  endtask

  // one-cycle round_start pulse; returns in the cycle after it was sampled
  task automatic pulse_start();
    bus_if.round_start = 1'b1;
    @(negedge clk);
    bus_if.round_start = 1'b0;
  endtask

  // from the LOAD cycle: observe restart over LOAD/ARM/FLY and the drawn parameters
  task automatic advance_to_fly(output logic [15:0] l, output logic [2:0] rs, output logic [20:0] p);
    l = lfsr_m;
    rs[2] = bus_if.duck_restart;
    @(negedge clk);
    rs[1] = bus_if.duck_restart;
    p = params();
    @(negedge clk);
    rs[0] = bus_if.duck_restart;
  endtask

  // fly one round to hit (shot after shot_at frames) or escape, then the hold period
  task automatic play_round(input bit hit, input int shot_at, output logic [1:0] flags);
    if (hit) begin
      send_frames(shot_at, -1);
      bus_if.duck_shot = 1'b1;
      bus_if.new_frame = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus_if.duck_shot = 1'b0;
      bus_if.new_frame = 1'b0;
    end else begin
      send_frames(RF, -1);
    end
    flags = {bus_if.duck_falling, bus_if.fly_away};
    send_frames(hit ? HF : EF, -1);
  endtask

  task automatic test_reset();
    logic saw;
    bus_if.new_frame = 1'b0;
    bus_if.round_start = 1'b0;
    bus_if.duck_shot = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== 38'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", all_outs(), 38'd0);
    end
    checks++;
    if (bus_if.game_over !== 1'b0) begin
      errors++; $display("FAIL reset_game_over: got %b expected 0", bus_if.game_over);
    end
    rst = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus_if.duck_restart !== 1'b0 || bus_if.round_active !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++; $display("FAIL idle_no_restart: got %b expected 0", saw);
    end
    $display("reset: outputs %h after release idle=%b", all_outs(), !saw);
  endtask

  task automatic test_round_start();
    logic [15:0] l;
    logic [2:0]  rs;
    logic [20:0] p;
    logic        in_range;
    pulse_start();
    advance_to_fly(l, rs, p);
    checks++;
    if (rs !== 3'b010) begin
      errors++; $display("FAIL restart_timing: got %b expected %b", rs, 3'b010);
    end
    checks++;
    if (p !== exp_params(l, 0)) begin
      errors++; $display("FAIL params_round0: got %h expected %h", p, exp_params(l, 0));
    end
    in_range = (p[19:15] >= 5'd2) && (p[19:15] <= 5'd9) && (p[9:0] >= 10'd256) && (p[9:0] <= 10'd767);
    checks++;
    if (in_range !== 1'b1) begin
      errors++; $display("FAIL param_range: got h=%0d x=%0d expected 2..9 / 256..767", p[19:15], p[9:0]);
    end
    checks++;
    if (bus_if.round_active !== 1'b1) begin
      errors++; $display("FAIL fly_entry: got round_active=%b expected 1", bus_if.round_active);
    end
    send_frames(2, -1);
    checks++;
    if (params() !== p || bus_if.round_active !== 1'b1) begin
      errors++; $display("FAIL params_stable: got %h active=%b expected %h active=1", params(), bus_if.round_active, p);
    end
    $display("round_start: lfsr=%h params=%h restart=%b", l, p, rs);
  endtask

  task automatic test_miss();
    logic [15:0] l;
    logic [2:0]  rs;
    logic [20:0] p;
    send_frames(1, -1);
    checks++;
    if ({bus_if.round_active, bus_if.fly_away} !== 2'b10) begin
      errors++; $display("FAIL fly_before_timeout: got %b expected 10", {bus_if.round_active, bus_if.fly_away});
    end
    send_frames(1, -1);
    exp_miss++;
    checks++;
    if ({bus_if.fly_away, bus_if.round_active, bus_if.miss_cnt, bus_if.shot_cnt} !== {2'b10, 4'(exp_miss), 4'(exp_shot)}) begin
      errors++; $display("FAIL timeout_escape: got %h expected %h",
        {bus_if.fly_away, bus_if.round_active, bus_if.miss_cnt, bus_if.shot_cnt}, {2'b10, 4'(exp_miss), 4'(exp_shot)});
    end
    bus_if.duck_shot = 1'b1;
    bus_if.round_start = 1'b1;
    @(negedge clk);
    bus_if.duck_shot = 1'b0;
    bus_if.round_start = 1'b0;
    checks++;
    if ({bus_if.fly_away, bus_if.duck_restart, score()} !== {2'b10, 1'b0, 4'(exp_shot), 4'(exp_miss), 4'(exp_round)}) begin
      errors++; $display("FAIL escape_ignores_inputs: got %h expected %h",
        {bus_if.fly_away, bus_if.duck_restart, score()}, {2'b10, 1'b0, 4'(exp_shot), 4'(exp_miss), 4'(exp_round)});
    end
    send_frames(EF - 1, -1);
    checks++;
    if (bus_if.fly_away !== 1'b1) begin
      errors++; $display("FAIL escape_hold: got fly_away=%b expected 1", bus_if.fly_away);
    end
    send_frames(1, -1);
    exp_round++;
    checks++;
    if ({bus_if.fly_away, bus_if.round_num} !== {1'b0, 4'(exp_round)}) begin
      errors++; $display("FAIL escape_exit: got %h expected %h", {bus_if.fly_away, bus_if.round_num}, {1'b0, 4'(exp_round)});
    end
    advance_to_fly(l, rs, p);
    checks++;
    if (rs !== 3'b010 || p !== exp_params(l, exp_round)) begin
      errors++; $display("FAIL round1_load: got rs=%b p=%h expected rs=010 p=%h", rs, p, exp_params(l, exp_round));
    end
    $display("miss: miss_cnt=%0d round_num=%0d params=%h", bus_if.miss_cnt, bus_if.round_num, p);
  endtask

  task automatic test_shot_boundary();
    logic [15:0] l;
    logic [2:0]  rs;
    logic [20:0] p;
    send_frames(RF - 1, -1);
    send_frames(1, 0);
    exp_shot++;
    checks++;
    if ({bus_if.duck_falling, bus_if.fly_away, bus_if.shot_cnt, bus_if.miss_cnt} !== {2'b10, 4'(exp_shot), 4'(exp_miss)}) begin
      errors++; $display("FAIL shot_wins_timeout: got %h expected %h",
        {bus_if.duck_falling, bus_if.fly_away, bus_if.shot_cnt, bus_if.miss_cnt}, {2'b10, 4'(exp_shot), 4'(exp_miss)});
    end
    send_frames(HF, 0);
    exp_round++;
    checks++;
    if ({bus_if.duck_falling, score()} !== {1'b0, 1'b0, 4'(exp_shot), 4'(exp_miss), 4'(exp_round)}) begin
      errors++; $display("FAIL hit_exit: got %h expected %h", {bus_if.duck_falling, score()},
        {1'b0, 1'b0, 4'(exp_shot), 4'(exp_miss), 4'(exp_round)});
    end
    advance_to_fly(l, rs, p);
    checks++;
    if (rs !== 3'b010 || p !== exp_params(l, exp_round)) begin
      errors++; $display("FAIL round2_load: got rs=%b p=%h expected rs=010 p=%h", rs, p, exp_params(l, exp_round));
    end
    $display("shot: shot_cnt=%0d miss_cnt=%0d round_num=%0d", bus_if.shot_cnt, bus_if.miss_cnt, bus_if.round_num);
  endtask

  task automatic test_game_over();
    logic [15:0] l;
    logic [2:0]  rs;
    logic [20:0] p;
    logic [1:0]  flags;
    logic        saw;
    bit          hit;
    hit = 1'($urandom_range(0, 1));
    play_round(hit, $urandom_range(0, RF - 1), flags);
    if (hit) exp_shot++;
    else     exp_miss++;
    checks++;
    if (flags !== (hit ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL last_round_outcome: got %b expected %b", flags, hit ? 2'b10 : 2'b01);
    end
    checks++;
    if (score() !== {1'b1, 4'(exp_shot), 4'(exp_miss), 4'(NR - 1)}) begin
      errors++; $display("FAIL game_over_state: got %h expected %h", score(), {1'b1, 4'(exp_shot), 4'(exp_miss), 4'(NR - 1)});
    end
    checks++;
    if (int'(bus_if.shot_cnt) + int'(bus_if.miss_cnt) !== NR) begin
      errors++; $display("FAIL round_total: got %0d expected %0d", int'(bus_if.shot_cnt) + int'(bus_if.miss_cnt), NR);
    end
    saw = 1'b0;
    repeat (4) begin
      bus_if.duck_shot = 1'($urandom_range(0, 1));
      bus_if.new_frame = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus_if.duck_restart !== 1'b0) saw = 1'b1;
    end
    bus_if.duck_shot = 1'b0;
    bus_if.new_frame = 1'b0;
    checks++;
    if ({saw, score()} !== {1'b0, 1'b1, 4'(exp_shot), 4'(exp_miss), 4'(NR - 1)}) begin
      errors++; $display("FAIL done_hold: got %h expected %h", {saw, score()}, {1'b0, 1'b1, 4'(exp_shot), 4'(exp_miss), 4'(NR - 1)});
    end
    pulse_start();
    exp_shot = 0;
    exp_miss = 0;
    exp_round = 0;
    checks++;
    if (score() !== 13'd0) begin
      errors++; $display("FAIL new_game_clear: got %h expected %h", score(), 13'd0);
    end
    advance_to_fly(l, rs, p);
    checks++;
    if (rs !== 3'b010 || p !== exp_params(l, 0)) begin
      errors++; $display("FAIL new_game_restart: got rs=%b p=%h expected rs=010 p=%h", rs, p, exp_params(l, 0));
    end
    $display("game_over: last hit=%0b, new game restart=%b params=%h", hit, rs, p);
  endtask

  task automatic test_random_games();
    logic [15:0] l;
    logic [2:0]  rs;
    logic [20:0] p;
    logic [1:0]  flags;
    bit          hit;
    int          sa;
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < NR; r++) begin
        hit = 1'($urandom_range(0, 1));
        sa = $urandom_range(0, RF - 1);
        play_round(hit, sa, flags);
        if (hit) exp_shot++;
        else     exp_miss++;
        checks++;
        if (flags !== (hit ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rand_outcome g%0d r%0d: got %b expected %b", g, r, flags, hit ? 2'b10 : 2'b01);
        end
        if (r < NR - 1) begin
          exp_round++;
          checks++;
          if (score() !== {1'b0, 4'(exp_shot), 4'(exp_miss), 4'(exp_round)}) begin
            errors++; $display("FAIL rand_score g%0d r%0d: got %h expected %h", g, r, score(),
              {1'b0, 4'(exp_shot), 4'(exp_miss), 4'(exp_round)});
          end
          advance_to_fly(l, rs, p);
          checks++;
          if (rs !== 3'b010 || p !== exp_params(l, exp_round)) begin
            errors++; $display("FAIL rand_load g%0d r%0d: got rs=%b p=%h expected rs=010 p=%h", g, r, rs, p, exp_params(l, exp_round));
          end
        end else begin
          checks++;
          if (score() !== {1'b1, 4'(exp_shot), 4'(exp_miss), 4'(exp_round)}) begin
            errors++; $display("FAIL rand_done g%0d: got %h expected %h", g, score(),
              {1'b1, 4'(exp_shot), 4'(exp_miss), 4'(exp_round)});
          end
          pulse_start();
          exp_shot = 0;
          exp_miss = 0;
          exp_round = 0;
          advance_to_fly(l, rs, p);
          checks++;
          if (rs !== 3'b010 || p !== exp_params(l, 0) || score() !== 13'd0) begin
            errors++; $display("FAIL rand_restart g%0d: got rs=%b p=%h score=%h expected rs=010 p=%h score=0",
              g, rs, p, score(), exp_params(l, 0));
          end
        end
        $display("game %0d round %0d: hit=%0b shot_at=%0d shot_cnt=%0d miss_cnt=%0d", g, r, hit, sa, exp_shot, exp_miss);
      end
    end
  endtask

  task automatic test_reset_mid_fly();
    logic [15:0] l;
    logic [2:0]  rs;
    logic [20:0] p;
    logic        saw;
    send_frames(1, -1);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 38'd0) begin
      errors++; $display("FAIL async_reset: got %h expected %h", all_outs(), 38'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (all_outs() !== 38'd0) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got %b expected 0", saw);
    end
    pulse_start();
    advance_to_fly(l, rs, p);
    checks++;
    if (rs !== 3'b010 || p !== exp_params(l, 0)) begin
      errors++; $display("FAIL post_reset_round: got rs=%b p=%h expected rs=010 p=%h", rs, p, exp_params(l, 0));
    end
    $display("reset_mid_fly: cleared, reseeded params=%h", p);
  endtask

  initial begin
    test_reset();
    test_round_start();
    test_miss();
    test_shot_boundary();
    test_game_over();
    test_random_games();
    test_reset_mid_fly();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

endmodule
